// File: rtl/uart_tx_sequencer_pkg.sv
// Shared definitions for the UART transmit sequencer and its RX-side siblings.
// State encodings are kept at 3 bits so both directions decode them identically.
package uart_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..ClkDiv-1 and wraps; restart forces the count to 0.
// tick marks the second-to-last cycle of each bit period, letting consumers register boundary-aligned outputs.
module baud_tick_gen #(
  parameter int unsigned ClkDiv = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == CntW'(ClkDiv - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign tick = (cnt == CntW'(ClkDiv - 2));

endmodule

// File: rtl/uart_tx_sequencer.sv
// Pops words from the TX FIFO and serializes them: start bit, data LSB-first, optional parity, stop bit(s).
// Frames run back-to-back (one FETCH cycle apart) while enable is high and the FIFO stays non-empty.
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned ClkDiv    = 16,
  parameter int unsigned ParityEn  = 0,
  parameter int unsigned ParityOdd = 0,
  parameter int unsigned StopBits  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_has_data,
  input  logic [DataWidth-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned BitW = $clog2(DataWidth + 1);

  tx_state_t            state;
  logic [DataWidth-1:0] shift;
  logic [BitW-1:0]      bit_cnt;
  logic                 par;
  logic                 tick;
  logic                 last_cyc;
  logic                 restart;
  logic                 start_ok;
  logic                 last_stop;

  assign restart   = (state == FETCH);
  assign start_ok  = enable && fifo_has_data;
  assign last_stop = (bit_cnt == BitW'(StopBits - 1));

  baud_tick_gen #(.ClkDiv(ClkDiv)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // The timer ticks one cycle early; last_cyc re-aligns it to the final cycle of each bit,
  // so transitions land on bit boundaries while frame_done can still be registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_read  <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      last_cyc   <= 1'b0;
    end else begin
      fifo_read  <= 1'b0;
      frame_done <= 1'b0;
      last_cyc   <= tick && !restart;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start_ok) begin
            state     <= FETCH;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FETCH: begin
          shift <= fifo_data;
          par   <= (^fifo_data) ^ (ParityOdd != 0);
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (last_cyc) begin
            tx      <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (last_cyc) begin
            if (bit_cnt == BitW'(DataWidth - 1)) begin
              bit_cnt <= '0;
              if (ParityEn != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BitW'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
          if (last_cyc) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tick && last_stop) begin
            frame_done <= 1'b1;
          end
          if (last_cyc) begin
            if (last_stop) begin
              bit_cnt <= '0;
              if (start_ok) begin
                state     <= FETCH;
                fifo_read <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + BitW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench: FIFO model feeds the sequencer, expected words are queued on push and
// compared against frames decoded from tx; two extra instances cover even and odd parity.
module tb_uart_tx_sequencer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       fifo_has_data;
  logic [7:0] fifo_data;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic       pe_has;
  logic [7:0] pe_data;
  logic       pe_read, pe_tx, pe_busy, pe_done;
  logic       po_read, po_tx, po_busy, po_done;

  uart_tx_sequencer #(.DataWidth(8), .ClkDiv(4), .ParityEn(0), .ParityOdd(0), .StopBits(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_has_data(fifo_has_data), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  uart_tx_sequencer #(.DataWidth(8), .ClkDiv(4), .ParityEn(1), .ParityOdd(0), .StopBits(1)) dut_pe (
    .clk(clk), .rst(rst), .enable(enable), .fifo_has_data(pe_has), .fifo_data(pe_data),
    .fifo_read(pe_read), .tx(pe_tx), .busy(pe_busy), .frame_done(pe_done)
  );

  uart_tx_sequencer #(.DataWidth(8), .ClkDiv(4), .ParityEn(1), .ParityOdd(1), .StopBits(1)) dut_po (
    .clk(clk), .rst(rst), .enable(enable), .fifo_has_data(pe_has), .fifo_data(pe_data),
    .fifo_read(po_read), .tx(po_tx), .busy(po_busy), .frame_done(po_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         start_cycs[$];
  bit         pend_pop = 1'b0;
  bit         in_frame = 1'b0;
  int         fcnt = 0;
  int         cyc = 0;
  int         frames = 0;
  int         pops = 0;
  int         done_cnt = 0;
  logic [9:0] fbits = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_has_data = 1'b1;
    fifo_data     = fifo_q[0];
  endtask

  task automatic monitor();
    logic [7:0] w;
    cyc++;
    if (frame_done) done_cnt++;
    if (fifo_read) begin
      pops++;
      pend_pop = 1'b1;
      check("pop_nonempty", 32'(fifo_q.size() != 0), 1);
    end
    if (rst) begin
      if (in_frame) begin
        in_frame = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      return;
    end
    if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame = 1'b1;
        fcnt = 0;
        start_cycs.push_back(cyc);
        check("busy_in_frame", 32'(busy), 1);
      end
    end else begin
      fcnt++;
    end
    if (in_frame) begin
      if (fcnt % 4 == 1) fbits[fcnt / 4] = tx;
      if (fcnt == 39) begin
        check("frame_done_pos", 32'(frame_done), 1);
        frames++;
        in_frame = 1'b0;
        if (exp_q.size() == 0) begin
          check("exp_available", 0, 1);
        end else begin
          w = exp_q.pop_front();
          check("frame_bits", 32'(fbits), 32'({1'b1, w, 1'b0}));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pend_pop) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pend_pop = 1'b0;
      fifo_has_data = (fifo_q.size() != 0);
      fifo_data     = fifo_has_data ? fifo_q[0] : 8'h00;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames < n && t < budget) begin
      step();
      t++;
    end
    check("frames_reached", 32'(frames >= n), 1);
  endtask

  task automatic wait_bit_pos(input int pos, input int budget);
    int t = 0;
    while (!(in_frame && fcnt == pos) && t < budget) begin
      step();
      t++;
    end
    check("bit_pos_reached", 32'(in_frame && fcnt == pos), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] pbits, obits;
    int          t;
    bit          seen;

    rst = 1'b1; enable = 1'b1;
    fifo_has_data = 1'b0; fifo_data = 8'h00;
    pe_has = 1'b0; pe_data = 8'h07;
    pbits = '0; obits = '0;

    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_read", 32'(fifo_read), 0);
    end
    check("rst_pe_tx", 32'(pe_tx), 1);
    rst = 1'b0;

    wait_frames(1, 100);
    check("single_pops", 32'(pops), 1);
    check("single_done", 32'(done_cnt), 1);
    repeat (5) step();
    check("idle_busy", 32'(busy), 0);
    check("idle_tx", 32'(tx), 1);

    push(8'h00);
    push(8'hFF);
    wait_frames(3, 150);
    check("b2b_pitch", 32'(start_cycs[2] - start_cycs[1]), 41);
    check("b2b_pops", 32'(pops), 3);
    repeat (5) step();
    check("b2b_idle_busy", 32'(busy), 0);
    check("b2b_done", 32'(done_cnt), 3);

    push(8'h3C);
    push(8'h5A);
    push(8'hC3);
    wait_bit_pos(16, 60);
    enable = 1'b0;
    wait_frames(4, 100);
    repeat (20) step();
    check("drop_pops", 32'(pops), 4);
    check("drop_has_data", 32'(fifo_has_data), 1);
    check("drop_busy", 32'(busy), 0);
    check("drop_tx", 32'(tx), 1);

    enable = 1'b1;
    wait_bit_pos(24, 80);
    rst = 1'b1;
    step();
    check("mrst_tx", 32'(tx), 1);
    check("mrst_busy", 32'(busy), 0);
    rst = 1'b0;
    wait_frames(5, 120);
    check("mrst_pops", 32'(pops), 6);
    repeat (5) step();
    check("mrst_done", 32'(done_cnt), 5);
    check("mrst_idle", 32'(busy), 0);

    pe_has = 1'b1;
    t = 0; seen = 1'b0;
    while (!seen && t < 10) begin
      step();
      seen = pe_read && po_read;
      t++;
    end
    check("par_pop", 32'(seen), 1);
    pe_has = 1'b0;
    t = 0;
    while (pe_tx !== 1'b0 && t < 10) begin
      step();
      t++;
    end
    check("par_start_seen", 32'(pe_tx), 0);
    for (int c = 0; c < 44; c++) begin
      if (c % 4 == 1) begin
        pbits[c / 4] = pe_tx;
        obits[c / 4] = po_tx;
      end
      if (c == 43) check("par_done", 32'({pe_done, po_done}), 32'(2'b11));
      if (c != 43) step();
    end
    check("par_even_frame", 32'(pbits), 32'({1'b1, ^pe_data, pe_data, 1'b0}));
    check("par_odd_frame", 32'(obits), 32'({1'b1, ~^pe_data, pe_data, 1'b0}));
    repeat (5) step();
    check("par_idle", 32'({pe_busy, po_busy}), 0);
    check("done_total", 32'(done_cnt), 32'(frames));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
